// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register busy/tag scoreboard.
// Two write ports (port 1 has priority), NR combinational read ports with
// write bypass. x0 reads as zero and is never busy.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NR   = 2,
  parameter int TW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w0_en,
  input  logic [AW-1:0]      w0_addr,
  input  logic [XLEN-1:0]    w0_data,
  input  logic [TW-1:0]      w0_tag,
  input  logic               w1_en,
  input  logic [AW-1:0]      w1_addr,
  input  logic [XLEN-1:0]    w1_data,
  input  logic [TW-1:0]      w1_tag,
  input  logic               set_en,
  input  logic [AW-1:0]      set_addr,
  input  logic [TW-1:0]      set_tag,
  input  logic               flush,
  input  logic [NR-1:0]      re,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*XLEN-1:0] rdata,
  output logic [NR-1:0]      rbusy,
  output logic [NR*TW-1:0]   rtag
);

  logic [XLEN-1:0] regs [NREG];
  logic [TW-1:0]   tags [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_v;
  logic [NREG-1:0] busy_nxt;

  // Tag-matched retire: a write only clears busy if it comes from the current producer.
  always_comb begin
    clr_v = '0;
    for (int r = 0; r < NREG; r++) begin
      clr_v[r] = (w0_en && (w0_addr == AW'(r)) && (tags[r] == w0_tag)) ||
                 (w1_en && (w1_addr == AW'(r)) && (tags[r] == w1_tag));
    end
  end

  // Next busy state: clear, then set (set wins), then flush (flush wins over all).
  always_comb begin
    busy_nxt = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_nxt[r] = busy[r] & ~clr_v[r];
      if (set_en && (set_addr == AW'(r))) busy_nxt[r] = 1'b1;
      if (flush) busy_nxt[r] = 1'b0;
    end
  end

  // Architectural state update; entry 0 is never written, tagged or marked busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w1_en && (w1_addr == AW'(r))) begin
          regs[r] <= w1_data;
        end else if (w0_en && (w0_addr == AW'(r))) begin
          regs[r] <= w0_data;
        end
        if (set_en && !flush && (set_addr == AW'(r))) begin
          tags[r] <= set_tag;
        end
      end
      busy <= busy_nxt;
    end
  end

  // Read ports: zero under reset / disabled / x0, otherwise bypass over array.
  // A same-cycle set or flush is deliberately not visible here.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    rtag  = '0;
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      a = raddr[i*AW +: AW];
      if (!rst && re[i] && (a != '0)) begin
        if (w1_en && (w1_addr == a)) begin
          rdata[i*XLEN +: XLEN] = w1_data;
        end else if (w0_en && (w0_addr == a)) begin
          rdata[i*XLEN +: XLEN] = w0_data;
        end else begin
          rdata[i*XLEN +: XLEN] = regs[a];
        end
        rbusy[i]          = busy[a] & ~clr_v[a];
        rtag[i*TW +: TW]  = tags[a];
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated scoreboard for the out-of-order issue stage. It has NR read ports and two write ports, and per-register busy bits with producer tags. The decode/issue stage reads operands plus their busy/tag status from it. Writeback writes data and retires the producer tag. x0 is hardwired zero and never busy.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, 5, address width (log2 NREG)
- NR, 2, number of read ports (1..4)
- TW, 4, producer tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- w0_en  in  1  write port 0 enable
- w0_addr  in  AW  write port 0 address
- w0_data  in  XLEN  write port 0 data
- w0_tag  in  TW  tag of producer retiring on port 0
- w1_en, w1_addr, w1_data, w1_tag  in  1/AW/XLEN/TW  write port 1, same meaning; higher priority than port 0
- set_en  in  1  issue marks a destination busy
- set_addr  in  AW  destination register
- set_tag  in  TW  tag of new producer
- flush  in  1  clears all busy bits (mispredict recovery)
- re  in  NR  per-port read enable
- raddr  in  NR*AW  packed read addresses, port i at [i*AW +: AW]
- rdata  out  NR*XLEN  packed read data
- rbusy  out  NR  register pending a producer
- rtag  out  NR*TW  pending producer tag, valid when rbusy=1

## Operation
- State: regs[NREG] of XLEN, busy[NREG], tag[NREG] of TW. Entry 0 is never written and never set busy.
- Write: on posedge, if wK_en and wK_addr≠0, then regs[wK_addr] ← wK_data. Data is written regardless of busy/tag match, because the write is architecturally ordered by commit.
- Same-address writes on both ports in one cycle: port 1 data wins.
- Busy clear: on posedge, for each port K with wK_en, busy[wK_addr] ← 0 only if busy=1 and tag[wK_addr]==wK_tag. A stale producer does not clear a newer one.
- Busy set: on posedge, if set_en and set_addr≠0, then busy[set_addr] ← 1 and tag[set_addr] ← set_tag.
- Set and clear of the same register in the same cycle: set wins.
- Flush: on posedge, all busy bits ← 0, and flush overrides a same-cycle set. Register data is unaffected, and writes that cycle still occur.
- Read port i (combinational), in priority order:
  - rst=1: rdata=0, rbusy=0, rtag=0.
  - re[i]=0 or raddr=0: all zero.
  - raddr matches an enabled write: rdata = write data, port 1 over port 0 (bypass). rbusy = busy after that cycle's tag-matched clear.
  - Otherwise: rdata=regs, rbusy=busy, rtag=tag.
- A same-cycle set is not visible on reads. Decode of rd=rs reads the old status, then marks busy.

## Timing
- Asynchronous reset: the instant rst asserts, all regs, busy and tag become 0. Outputs are 0 while rst=1. Reset mid-operation discards in-flight sets and writes.
- Write-to-read latency: 0 cycles via bypass, 1 cycle via the array.
- Busy set latency: visible on rbusy the cycle after set_en.
- Busy clear latency: 0 cycles via bypass for a matching write, persisting from the next cycle.
- No handshake and no stall: every request is accepted every cycle.

## Test plan
- Reset: load regs[3]=0x55, assert rst asynchronously between edges -> rdata for x3 reads 0 immediately; after release, x3 reads 0 and rbusy=0.
- Bypass and priority: w0 writes x5=0x11 and w1 writes x5=0x22 in the same cycle, read port 0 reads x5 -> rdata=0x22 that cycle and the next.
- x0 protection: w1 writes x0=0xFFFFFFFF and set_en on x0 -> x0 reads 0 with rbusy=0 forever.
- Tag match:
  - set x7 with tag 3, then set x7 with tag 5.
  - Write x7 with tag 3 -> data updated, rbusy stays 1, rtag=5.
  - Write x7 with tag 5 -> rbusy=0 in the same cycle.
- Set vs clear/flush: set x9 with tag 2 while w0 clears x9 with tag 2 -> busy=1, tag=2 next cycle. Set x9 with flush=1 -> busy=0 for all registers next cycle.
- Read-then-set: read x4 (not busy) while set_en on x4 -> rbusy=0 this cycle, 1 next cycle, on all NR ports.
